controller_device: RTL and testbench
====================================

Name: controller_device

Overview:
- Clocked emulation of a PSX pad: the responder end of the pad serial link that controller_io initiates.
- Samples host ATT/COMMAND/c_clk, shifts out the pad reply on DATA and pulses ACK after each non-final byte.
- Used as the bench/loopback partner for controller_io and for driving a board-level pad port from FPGA-side button state.

Parameters:
- ACK_DELAY, 8: clk cycles from detected 8th c_clk rise of a byte to ACK assertion (min 1).
- ACK_WIDTH, 4: clk cycles ACK held low (min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ATT  in  1  host select, active low, asynchronous to clk
- COMMAND  in  1  host command bit, LSB first, asynchronous
- c_clk  in  1  host serial clock, idle high, asynchronous
- DATA  out  1  reply bit, LSB first, idles 1
- ACK  out  1  acknowledge, active low, idles 1
- SLCT, STRT, UP, DOWN, RGHT, LEFT  in  1 each  buttons, 1 = pressed
- L1, L2, R1, R2, TRI, SQU, XXX, CIR  in  1 each  buttons, 1 = pressed
- LJOY, RJOY  in  1 each  stick clicks (L3/R3), 1 = pressed
- RJOY_X, RJOY_Y, LJOY_X, LJOY_Y  in  8 each  stick axes
- polled  out  1  one-cycle pulse when a full poll completes

Behaviour:
- Reset: DATA=1, ACK=1, polled=0, state IDLE, byte index 0, shift registers 0.
- Sync: ATT, COMMAND and c_clk each pass through a 2-flop synchroniser; c_clk edges are detected on the synced value. Rise detection = 3 clk after the pin edge.
- Reply bytes, indexed from 0: 0xFF, ID, 0x5A, B3, B4, then analog bytes if enabled.
  - B3 = ~{LEFT,DOWN,RGHT,UP,STRT,RJOY,LJOY,SLCT}, bit7 first in this list.
  - B4 = ~{SQU,XXX,CIR,TRI,R1,L1,R2,L2}, bit7 first in this list.
- Snapshot: all button and axis inputs are latched on the clk where synced ATT is first seen low. Reply bytes are built from the snapshot only.
- State machine:
  - IDLE: on synced ATT=0, snapshot inputs, load byte 0, DATA=bit0 -> SHIFT.
  - SHIFT:
    - Each detected c_clk fall: DATA = next tx bit.
    - Each detected c_clk rise: shift COMMAND into rx (LSB first), bitcnt++.
    - On the 8th rise, check rx: byte 0 must equal 0x01 and byte 1 must equal 0x42, else -> DONE. Byte 2 onward: rx ignored.
    - If the byte was not last -> ACK_WAIT; if last -> pulse polled for 1 clk -> DONE.
  - ACK_WAIT: count ACK_DELAY cycles, then ACK=0 and load next byte (DATA=bit0, bitcnt=0) -> ACK_PULSE.
  - ACK_PULSE: hold ACK=0 for ACK_WIDTH cycles, then ACK=1 -> SHIFT. c_clk edges seen during ACK_PULSE are still honoured as SHIFT edges.
  - DONE: DATA=1, ACK=1; ignore c_clk until synced ATT=1.
- Synced ATT=1 in any state: next clk -> IDLE, DATA=1, ACK=1, ACK counters cleared, no polled pulse. This has priority over every other event.
- A c_clk fall with bitcnt=8 (before the next load) leaves DATA unchanged.
- rst mid-transaction: all state returns to reset values on that clk. The device stays in IDLE until synced ATT is seen low again, including if ATT is already low when rst deasserts.

Optional Feature:
- CONTROLLER_DEVICE_ANALOG_EN defined: ID=0x73, 9 bytes. Bytes 5..8 = RJOY_X, RJOY_Y, LJOY_X, LJOY_Y (raw). 8 ACK pulses per poll.
- Undefined: ID=0x41, 5 bytes, 4 ACK pulses; axis inputs unused.

Test Plan:
- Digital poll: host sends 01,42,00,00,00 with SLCT=UP=CIR=1, others 0 -> DATA bytes FF,41,5A,EE,DF; 4 ACK pulses; one polled pulse after byte 4.
- First command 0x81 (memory-card address) -> no ACK; DATA=1 for the rest of ATT low; no polled pulse; the next 01/42 poll replies normally.
- ACK timing, ACK_DELAY=8, ACK_WIDTH=4 -> ACK falls exactly 8 clk after the 8th detected rise and stays low exactly 4 clk.
- ATT raised during bit 3 of byte 2 -> DATA=1 and ACK=1 within 3 clk; no polled pulse; the next poll starts at byte 0 (0xFF).
- Buttons changed mid-poll (SQU set during byte 3) -> B4 still reflects the snapshot taken at ATT fall (0xFF when no buttons were pressed then).
- With CONTROLLER_DEVICE_ANALOG_EN, axes 80,7F,00,FF -> bytes FF,73,5A,B3,B4,80,7F,00,FF; 8 ACK pulses; rst asserted at byte 6 -> DATA=1, ACK=1 next clk.

Source files
------------

// File: rtl/controller_device.sv
`default_nettype none
// ============================================================================
// Module  : controller_device
// Brief   : PSX pad responder. Replies FF,ID,5A,B3,B4[,axes] on DATA and pulses
//           ACK after every non-final byte. Define CONTROLLER_DEVICE_ANALOG_EN
//           for the 9-byte analog reply (ID 0x73); default is digital (ID 0x41).
// Revision: 1.0 - initial release
// ============================================================================
module controller_device #(
    parameter int ACK_DELAY = 8,
    parameter int ACK_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ATT,
    input  logic       COMMAND,
    input  logic       c_clk,
    output logic       DATA,
    output logic       ACK,
    input  logic       SLCT,
    input  logic       STRT,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       RGHT,
    input  logic       LEFT,
    input  logic       L1,
    input  logic       L2,
    input  logic       R1,
    input  logic       R2,
    input  logic       TRI,
    input  logic       SQU,
    input  logic       XXX,
    input  logic       CIR,
    input  logic       LJOY,
    input  logic       RJOY,
    input  logic [7:0] RJOY_X,
    input  logic [7:0] RJOY_Y,
    input  logic [7:0] LJOY_X,
    input  logic [7:0] LJOY_Y,
    output logic       polled
);

`ifdef CONTROLLER_DEVICE_ANALOG_EN
    localparam logic [7:0] c_PAD_ID    = 8'h73;
    localparam logic [3:0] c_LAST_BYTE = 4'd8;
`else
    localparam logic [7:0] c_PAD_ID    = 8'h41;
    localparam logic [3:0] c_LAST_BYTE = 4'd4;
`endif

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SHIFT     = 3'd1;
    localparam logic [2:0] c_ST_ACK_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_ACK_PULSE = 3'd3;
    localparam logic [2:0] c_ST_DONE      = 3'd4;

    localparam logic [15:0] c_DELAY_LAST = 16'(ACK_DELAY - 1);
    localparam logic [15:0] c_WIDTH_LAST = 16'(ACK_WIDTH - 1);

    logic       r_att_s1, r_att_s2;
    logic       r_cmd_s1, r_cmd_s2;
    logic       r_cclk_s1, r_cclk_s2, r_cclk_d;
    logic [2:0] r_state;
    logic [3:0] r_byte_idx;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [15:0] r_cnt;
    logic       r_data, r_ack, r_polled;
    logic [7:0] r_snap_b3, r_snap_b4;
    logic [7:0] r_snap_rx, r_snap_ry, r_snap_lx, r_snap_ly;

    logic       w_rise, w_fall;
    logic [7:0] w_rx_next;
    logic [3:0] w_next_idx;
    logic [7:0] w_next_byte;
    logic       w_hdr_bad;

    // Host pins are asynchronous; idle levels on reset avoid phantom edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_att_s1  <= 1'b1;
            r_att_s2  <= 1'b1;
            r_cmd_s1  <= 1'b0;
            r_cmd_s2  <= 1'b0;
            r_cclk_s1 <= 1'b1;
            r_cclk_s2 <= 1'b1;
            r_cclk_d  <= 1'b1;
        end else begin
            r_att_s1  <= ATT;
            r_att_s2  <= r_att_s1;
            r_cmd_s1  <= COMMAND;
            r_cmd_s2  <= r_cmd_s1;
            r_cclk_s1 <= c_clk;
            r_cclk_s2 <= r_cclk_s1;
            r_cclk_d  <= r_cclk_s2;
        end
    end

    always_comb begin
        w_rise     = r_cclk_s2 & ~r_cclk_d;
        w_fall     = ~r_cclk_s2 & r_cclk_d;
        w_rx_next  = {r_cmd_s2, r_rx[7:1]};
        w_next_idx = r_byte_idx + 4'd1;
        w_hdr_bad  = ((r_byte_idx == 4'd0) && (w_rx_next != 8'h01)) ||
                     ((r_byte_idx == 4'd1) && (w_rx_next != 8'h42));
        case (w_next_idx)
            4'd1:    w_next_byte = c_PAD_ID;
            4'd2:    w_next_byte = 8'h5A;
            4'd3:    w_next_byte = r_snap_b3;
            4'd4:    w_next_byte = r_snap_b4;
            4'd5:    w_next_byte = r_snap_rx;
            4'd6:    w_next_byte = r_snap_ry;
            4'd7:    w_next_byte = r_snap_lx;
            4'd8:    w_next_byte = r_snap_ly;
            default: w_next_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_byte_idx <= 4'd0;
            r_bit_cnt  <= 4'd0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_cnt      <= 16'd0;
            r_data     <= 1'b1;
            r_ack      <= 1'b1;
            r_polled   <= 1'b0;
            r_snap_b3  <= 8'h00;
            r_snap_b4  <= 8'h00;
            r_snap_rx  <= 8'h00;
            r_snap_ry  <= 8'h00;
            r_snap_lx  <= 8'h00;
            r_snap_ly  <= 8'h00;
        end else begin
            r_polled <= 1'b0;
            if (r_att_s2) begin
                // Deselect aborts everything, whatever else happens this cycle.
                r_state    <= c_ST_IDLE;
                r_data     <= 1'b1;
                r_ack      <= 1'b1;
                r_cnt      <= 16'd0;
                r_byte_idx <= 4'd0;
                r_bit_cnt  <= 4'd0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_snap_b3  <= ~{LEFT, DOWN, RGHT, UP, STRT, RJOY, LJOY, SLCT};
                        r_snap_b4  <= ~{SQU, XXX, CIR, TRI, R1, L1, R2, L2};
                        r_snap_rx  <= RJOY_X;
                        r_snap_ry  <= RJOY_Y;
                        r_snap_lx  <= LJOY_X;
                        r_snap_ly  <= LJOY_Y;
                        r_tx       <= 8'hFF;
                        r_data     <= 1'b1;
                        r_byte_idx <= 4'd0;
                        r_bit_cnt  <= 4'd0;
                        r_rx       <= 8'h00;
                        r_state    <= c_ST_SHIFT;
                    end
                    c_ST_SHIFT, c_ST_ACK_PULSE: begin
                        if (r_state == c_ST_ACK_PULSE) begin
                            if (r_cnt == c_WIDTH_LAST) begin
                                r_ack   <= 1'b1;
                                r_cnt   <= 16'd0;
                                r_state <= c_ST_SHIFT;
                            end else begin
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end
                        if (w_fall && !r_bit_cnt[3])
                            r_data <= r_tx[r_bit_cnt[2:0]];
                        if (w_rise && !r_bit_cnt[3]) begin
                            r_rx      <= w_rx_next;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_ack <= 1'b1;
                                r_cnt <= 16'd0;
                                if (w_hdr_bad) begin
                                    r_data  <= 1'b1;
                                    r_state <= c_ST_DONE;
                                end else if (r_byte_idx == c_LAST_BYTE) begin
                                    r_data   <= 1'b1;
                                    r_polled <= 1'b1;
                                    r_state  <= c_ST_DONE;
                                end else begin
                                    r_state <= c_ST_ACK_WAIT;
                                end
                            end
                        end
                    end
                    c_ST_ACK_WAIT: begin
                        if (r_cnt == c_DELAY_LAST) begin
                            r_ack      <= 1'b0;
                            r_tx       <= w_next_byte;
                            r_data     <= w_next_byte[0];
                            r_byte_idx <= w_next_idx;
                            r_bit_cnt  <= 4'd0;
                            r_cnt      <= 16'd0;
                            r_state    <= c_ST_ACK_PULSE;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    c_ST_DONE: begin
                        r_data <= 1'b1;
                        r_ack  <= 1'b1;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign DATA   = r_data;
    assign ACK    = r_ack;
    assign polled = r_polled;

endmodule
`default_nettype wire

// File: tb/tb_controller_device.sv
`default_nettype none
// ============================================================================
// Module  : tb_controller_device
// Brief   : Emulated PSX host driving controller_device; replies are compared
//           against a byte-list model of the pad built from the button snapshot.
// Revision: 1.0 - initial release
// ============================================================================
module tb_controller_device;

    localparam int c_ACK_DELAY = 8;
    localparam int c_ACK_WIDTH = 4;
    localparam int c_HALF      = 6;
`ifdef CONTROLLER_DEVICE_ANALOG_EN
    localparam int         c_NB = 9;
    localparam logic [7:0] c_ID = 8'h73;
`else
    localparam int         c_NB = 5;
    localparam logic [7:0] c_ID = 8'h41;
`endif

    logic clk = 1'b0;
    logic rst, ATT, COMMAND, c_clk;
    logic DATA, ACK, polled;
    logic SLCT, STRT, UP, DOWN, RGHT, LEFT, L1, L2, R1, R2, TRI, SQU, XXX, CIR, LJOY, RJOY;
    logic [7:0] RJOY_X, RJOY_Y, LJOY_X, LJOY_Y;

    always #5 clk = ~clk;

    controller_device #(.ACK_DELAY(c_ACK_DELAY), .ACK_WIDTH(c_ACK_WIDTH)) dut (
        .clk(clk), .rst(rst), .ATT(ATT), .COMMAND(COMMAND), .c_clk(c_clk),
        .DATA(DATA), .ACK(ACK),
        .SLCT(SLCT), .STRT(STRT), .UP(UP), .DOWN(DOWN), .RGHT(RGHT), .LEFT(LEFT),
        .L1(L1), .L2(L2), .R1(R1), .R2(R2), .TRI(TRI), .SQU(SQU), .XXX(XXX), .CIR(CIR),
        .LJOY(LJOY), .RJOY(RJOY),
        .RJOY_X(RJOY_X), .RJOY_Y(RJOY_Y), .LJOY_X(LJOY_X), .LJOY_Y(LJOY_Y),
        .polled(polled)
    );

    int n_pass = 0;
    int n_total = 0;
    int ack_falls = 0;
    int polled_cnt = 0;
    logic ack_q = 1'b1;
    logic [7:0] snap [9];
    logic [7:0] rx_bytes [9];
    logic [7:0] got_byte;

    always @(negedge clk) begin
        if (ack_q === 1'b1 && ACK === 1'b0) ack_falls++;
        if (polled === 1'b1) polled_cnt++;
        ack_q = ACK;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_buttons(input logic [15:0] v);
        {SLCT, STRT, UP, DOWN, RGHT, LEFT, L1, L2, R1, R2, TRI, SQU, XXX, CIR, LJOY, RJOY} = v;
    endtask

    // Pad reply model: what the pad must say, given its inputs when selected.
    task automatic take_snapshot();
        snap[0] = 8'hFF;
        snap[1] = c_ID;
        snap[2] = 8'h5A;
        snap[3] = ~{LEFT, DOWN, RGHT, UP, STRT, RJOY, LJOY, SLCT};
        snap[4] = ~{SQU, XXX, CIR, TRI, R1, L1, R2, L2};
        snap[5] = RJOY_X;
        snap[6] = RJOY_Y;
        snap[7] = LJOY_X;
        snap[8] = LJOY_Y;
    endtask

    task automatic send_byte(input logic [7:0] cmd, input bit want_ack);
        int first;
        int width;
        for (int i = 0; i < 8; i++) begin
            c_clk = 1'b0;
            COMMAND = cmd[i];
            tick(c_HALF);
            got_byte[i] = DATA;
            c_clk = 1'b1;
            if (i < 7) tick(c_HALF);
        end
        first = -1;
        width = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (ACK === 1'b0) begin
                if (first < 0) first = k;
                width++;
            end
        end
        // 2 sync flops + 1 detect cycle precede the ACK delay count.
        if (want_ack) begin
            chk("ack_delay", first, 3 + c_ACK_DELAY);
            chk("ack_width", width, c_ACK_WIDTH);
        end else begin
            chk("no_ack", width, 0);
        end
    endtask

    task automatic do_poll(input logic [7:0] cmd0, input int nsend, input int squ_at,
                           output int d_ack, output int d_pol);
        int a0;
        int p0;
        a0 = ack_falls;
        p0 = polled_cnt;
        take_snapshot();
        ATT = 1'b0;
        tick(c_HALF);
        for (int b = 0; b < nsend; b++) begin
            if (b == squ_at) SQU = 1'b1;
            send_byte(b == 0 ? cmd0 : (b == 1 ? 8'h42 : 8'h00), cmd0 == 8'h01 && b < c_NB - 1);
            rx_bytes[b] = got_byte;
        end
        tick(4);
        ATT = 1'b1;
        tick(2 * c_HALF);
        d_ack = ack_falls - a0;
        d_pol = polled_cnt - p0;
    endtask

    task automatic check_full(input string tag, input int squ_at);
        int da;
        int dp;
        do_poll(8'h01, c_NB, squ_at, da, dp);
        for (int b = 0; b < c_NB; b++)
            chk($sformatf("%s_byte%0d", tag, b), rx_bytes[b], snap[b]);
        chk($sformatf("%s_acks", tag), da, c_NB - 1);
        chk($sformatf("%s_polled", tag), dp, 1);
    endtask

    initial begin
        int da;
        int dp;
        int a0;
        int p0;
        rst = 1'b1; ATT = 1'b1; c_clk = 1'b1; COMMAND = 1'b1;
        set_buttons(16'h0000);
        RJOY_X = 8'h00; RJOY_Y = 8'h00; LJOY_X = 8'h00; LJOY_Y = 8'h00;
        tick(3);
        chk("rst_data", DATA, 1);
        chk("rst_ack", ACK, 1);
        chk("rst_polled", polled, 0);
        rst = 1'b0;
        tick(4);

        // Directed digital poll: SLCT, UP, CIR pressed.
        SLCT = 1'b1; UP = 1'b1; CIR = 1'b1;
        RJOY_X = 8'h80; RJOY_Y = 8'h7F; LJOY_X = 8'h00; LJOY_Y = 8'hFF;
        check_full("dir", -1);
        chk("dir_b3_const", rx_bytes[3], 8'hEE);
        chk("dir_b4_const", rx_bytes[4], 8'hDF);

        // Memory-card address: pad must stay silent, then answer a normal poll.
        do_poll(8'h81, 3, -1, da, dp);
        for (int b = 0; b < 3; b++) chk($sformatf("mc_byte%0d", b), rx_bytes[b], 8'hFF);
        chk("mc_acks", da, 0);
        chk("mc_polled", dp, 0);
        check_full("after_mc", -1);

        // Deselect in the middle of byte 2.
        a0 = ack_falls; p0 = polled_cnt;
        take_snapshot();
        ATT = 1'b0;
        tick(c_HALF);
        send_byte(8'h01, 1'b1);
        send_byte(8'h42, 1'b1);
        for (int i = 0; i < 3; i++) begin
            c_clk = 1'b0; COMMAND = 1'b0; tick(c_HALF);
            c_clk = 1'b1; tick(c_HALF);
        end
        chk("abort_pre_data", DATA, 0);
        ATT = 1'b1;
        tick(3);
        chk("abort_data", DATA, 1);
        chk("abort_ack", ACK, 1);
        tick(20);
        chk("abort_polled", polled_cnt - p0, 0);
        chk("abort_acks", ack_falls - a0, 2);
        check_full("after_abort", -1);

        // Buttons change mid-poll; reply must reflect the select-time snapshot.
        set_buttons(16'h0000);
        SQU = 1'b0;
        check_full("snap", 3);
        chk("snap_b4_const", rx_bytes[4], 8'hFF);
        SQU = 1'b0;

        // Reset while byte 3 (all direction/system buttons pressed -> 0x00) shifts out.
        set_buttons(16'h0000);
        {LEFT, DOWN, RGHT, UP, STRT, RJOY, LJOY, SLCT} = 8'hFF;
        p0 = polled_cnt;
        take_snapshot();
        ATT = 1'b0;
        tick(c_HALF);
        send_byte(8'h01, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h00, 1'b1);
        c_clk = 1'b0;
        tick(c_HALF);
        chk("rst_pre_data", DATA, 0);
        rst = 1'b1;
        tick(1);
        chk("midrst_data", DATA, 1);
        chk("midrst_ack", ACK, 1);
        chk("midrst_polled", polled, 0);
        rst = 1'b0;
        c_clk = 1'b1;
        tick(10);
        ATT = 1'b1;
        tick(2 * c_HALF);
        chk("midrst_no_poll", polled_cnt - p0, 0);
        set_buttons(16'h0000);
        check_full("after_rst", -1);

        // Randomized polls.
        for (int r = 0; r < 6; r++) begin
            set_buttons(16'($urandom));
            RJOY_X = 8'($urandom); RJOY_Y = 8'($urandom);
            LJOY_X = 8'($urandom); LJOY_Y = 8'($urandom);
            check_full($sformatf("rnd%0d", r), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
